lc3_control_fsm: RTL and testbench

LC3_CONTROL_FSM -- requirements
Module: lc3_control_fsm

---
 rtl/lc3_control_fsm_pkg.sv | 73 +++++++
 rtl/lc3_wait_timer.sv | 39 +++
 rtl/lc3_control_fsm.sv | 226 ++++++++++++++++++++++
 tb/tb_lc3_control_fsm.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_control_fsm_pkg.sv
// Shared definitions for the LC-3 control FSM: opcode and state enums, datapath select
// encodings and a wait-state classifier. Monitors and checkers import the same package so
// that every party decodes the select fields identically.
package lc3_control_fsm_pkg;

    typedef enum logic [3:0] {
        OpBr   = 4'd0,
        OpAdd  = 4'd1,
        OpLd   = 4'd2,
        OpSt   = 4'd3,
        OpJsr  = 4'd4,
        OpAnd  = 4'd5,
        OpLdr  = 4'd6,
        OpStr  = 4'd7,
        OpRti  = 4'd8,
        OpNot  = 4'd9,
        OpLdi  = 4'd10,
        OpSti  = 4'd11,
        OpJmp  = 4'd12,
        OpRes  = 4'd13,
        OpLea  = 4'd14,
        OpTrap = 4'd15
    } opcode_e;

    typedef enum logic [4:0] {
        StFetch  = 5'd0,
        StFwait  = 5'd1,
        StLdir   = 5'd2,
        StDecode = 5'd3,
        StExec   = 5'd4,
        StMaddr  = 5'd5,
        StIwait  = 5'd6,
        StIload  = 5'd7,
        StRwait  = 5'd8,
        StLdwb   = 5'd9,
        StStdata = 5'd10,
        StWwait  = 5'd11,
        StTrap0  = 5'd12,
        StTwait  = 5'd13,
        StTrap1  = 5'd14,
        StHalt   = 5'd15
    } state_e;

    // pc_sel
    localparam logic [1:0] PcSelInc   = 2'd0;
    localparam logic [1:0] PcSelEa    = 2'd1;
    localparam logic [1:0] PcSelBase  = 2'd2;
    localparam logic [1:0] PcSelMdr   = 2'd3;
    // mar_sel
    localparam logic [1:0] MarSelPc   = 2'd0;
    localparam logic [1:0] MarSelEa   = 2'd1;
    localparam logic [1:0] MarSelMdr  = 2'd2;
    localparam logic [1:0] MarSelVect = 2'd3;
    // ea_sel
    localparam logic [1:0] EaSelOff9  = 2'd0;
    localparam logic [1:0] EaSelOff6  = 2'd1;
    localparam logic [1:0] EaSelOff11 = 2'd2;
    // reg_sel
    localparam logic [1:0] RegSelAlu  = 2'd0;
    localparam logic [1:0] RegSelMdr  = 2'd1;
    localparam logic [1:0] RegSelPc   = 2'd2;
    localparam logic [1:0] RegSelEa   = 2'd3;
    // alu_op
    localparam logic [1:0] AluAdd     = 2'd0;
    localparam logic [1:0] AluAnd     = 2'd1;
    localparam logic [1:0] AluNot     = 2'd2;

    function automatic logic is_wait(input state_e s);
        return (s == StFwait) || (s == StIwait) || (s == StRwait) ||
               (s == StWwait) || (s == StTwait);
    endfunction

endpackage

// File: rtl/lc3_wait_timer.sv
// Memory-wait watchdog.
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   in_wait_i     : FSM is in a memory-wait state
//   mem_ready_i   : memory completes the access this cycle
//   expired_o     : this is the WAIT_MAX-th consecutive non-ready wait cycle
// The count is zero on the first cycle of every wait state, so expiry lands exactly on the
// WAIT_MAX-th wait cycle; a ready in that same cycle suppresses expiry.
module lc3_wait_timer #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic in_wait_i,
    input  logic mem_ready_i,
    output logic expired_o
);

    localparam logic [7:0] Limit = 8'(WAIT_MAX - 1);

    logic [7:0] count_q, count_d;

    always_comb begin
        count_d = 8'd0;
        if (in_wait_i) begin
            count_d = (mem_ready_i || count_q == 8'hFF) ? count_q : count_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = in_wait_i && !mem_ready_i && (count_q == Limit);

endmodule

// File: rtl/lc3_control_fsm.sv
// LC-3 multicycle control FSM.
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   ir_i, nzp_i         : instruction register and condition codes
//   mem_ready_i         : memory completes the current access
//   mem_en_o, mem_we_o  : memory request / write qualifier
//   ld_*_o              : datapath load enables
//   *_sel_o, alu_op_o   : datapath selects (encodings in lc3_control_fsm_pkg)
//   dr_r7_o, mdr_sel_o  : force R7 destination, MDR source
//   illegal_o, mem_err_o: sticky fault flags; state_o: debug state encoding
// Outputs decode from the registered state; only ld_mdr in read waits (and the timeout
// abort) depend combinationally on mem_ready_i.
module lc3_control_fsm
    import lc3_control_fsm_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] ir_i,
    input  logic [2:0]  nzp_i,
    input  logic        mem_ready_i,
    output logic        mem_en_o,
    output logic        mem_we_o,
    output logic        ld_pc_o,
    output logic        ld_ir_o,
    output logic        ld_mar_o,
    output logic        ld_mdr_o,
    output logic        ld_reg_o,
    output logic        ld_cc_o,
    output logic [1:0]  pc_sel_o,
    output logic [1:0]  mar_sel_o,
    output logic [1:0]  ea_sel_o,
    output logic [1:0]  reg_sel_o,
    output logic        dr_r7_o,
    output logic        mdr_sel_o,
    output logic [1:0]  alu_op_o,
    output logic        illegal_o,
    output logic        mem_err_o,
    output logic [4:0]  state_o
);

    state_e  state_q, state_d;
    logic    illegal_q, illegal_d;
    logic    mem_err_q, mem_err_d;
    logic    timeout;
    opcode_e op;
    logic    unused_ir;

    assign op        = opcode_e'(ir_i[15:12]);
    assign unused_ir = ^ir_i[8:0];
    assign state_o   = state_q;

    lc3_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_wait_i   (is_wait(state_q)),
        .mem_ready_i (mem_ready_i),
        .expired_o   (timeout)
    );

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        mem_err_d = mem_err_q;
        {mem_en_o, mem_we_o, ld_pc_o, ld_ir_o, ld_mar_o, ld_mdr_o, ld_reg_o, ld_cc_o,
         pc_sel_o, mar_sel_o, ea_sel_o, reg_sel_o, dr_r7_o, mdr_sel_o, alu_op_o} = '0;

        unique case (state_q)
            StFetch: begin
                ld_mar_o  = 1'b1;
                mar_sel_o = MarSelPc;
                ld_pc_o   = 1'b1;
                pc_sel_o  = PcSelInc;
                state_d   = StFwait;
            end
            StFwait, StIwait, StRwait, StTwait: begin
                mem_en_o = 1'b1;
                ld_mdr_o = mem_ready_i;
                if (mem_ready_i) begin
                    unique case (state_q)
                        StFwait: state_d = StLdir;
                        StIwait: state_d = StIload;
                        StRwait: state_d = StLdwb;
                        default: state_d = StTrap1;
                    endcase
                end
            end
            StLdir: begin
                ld_ir_o = 1'b1;
                state_d = StDecode;
            end
            StDecode: begin
                case (op)
                    OpBr: begin
                        if ((ir_i[11:9] & nzp_i) != 3'b000) begin
                            ld_pc_o  = 1'b1;
                            pc_sel_o = PcSelEa;
                            ea_sel_o = EaSelOff9;
                        end
                        state_d = StFetch;
                    end
                    OpJmp: begin
                        ld_pc_o  = 1'b1;
                        pc_sel_o = PcSelBase;
                        state_d  = StFetch;
                    end
                    OpAdd, OpAnd, OpNot, OpLea, OpJsr:       state_d = StExec;
                    OpLd, OpLdr, OpLdi, OpSt, OpStr, OpSti: state_d = StMaddr;
                    OpTrap:                                  state_d = StTrap0;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = StHalt;
                    end
                endcase
            end
            StExec: begin
                case (op)
                    OpAdd, OpAnd, OpNot: begin
                        ld_reg_o  = 1'b1;
                        ld_cc_o   = 1'b1;
                        reg_sel_o = RegSelAlu;
                        alu_op_o  = (op == OpAdd) ? AluAdd : (op == OpAnd) ? AluAnd : AluNot;
                    end
                    OpLea: begin
                        ld_reg_o  = 1'b1;
                        reg_sel_o = RegSelEa;
                        ea_sel_o  = EaSelOff9;
                    end
                    OpJsr: begin
                        // R7 takes the pre-update PC because both loads share this edge
                        ld_reg_o  = 1'b1;
                        reg_sel_o = RegSelPc;
                        dr_r7_o   = 1'b1;
                        ld_pc_o   = 1'b1;
                        if (ir_i[11]) begin
                            pc_sel_o = PcSelEa;
                            ea_sel_o = EaSelOff11;
                        end else begin
                            pc_sel_o = PcSelBase;
                        end
                    end
                    default: ;
                endcase
                state_d = StFetch;
            end
            StMaddr: begin
                ld_mar_o  = 1'b1;
                mar_sel_o = MarSelEa;
                ea_sel_o  = (op == OpLdr || op == OpStr) ? EaSelOff6 : EaSelOff9;
                case (op)
                    OpLdi, OpSti: state_d = StIwait;
                    OpLd, OpLdr:  state_d = StRwait;
                    default:      state_d = StStdata;
                endcase
            end
            StIload: begin
                ld_mar_o  = 1'b1;
                mar_sel_o = MarSelMdr;
                state_d   = (op == OpLdi) ? StRwait : StStdata;
            end
            StLdwb: begin
                ld_reg_o  = 1'b1;
                ld_cc_o   = 1'b1;
                reg_sel_o = RegSelMdr;
                state_d   = StFetch;
            end
            StStdata: begin
                ld_mdr_o  = 1'b1;
                mdr_sel_o = 1'b1;
                state_d   = StWwait;
            end
            StWwait: begin
                mem_en_o = 1'b1;
                mem_we_o = 1'b1;
                if (mem_ready_i) state_d = StFetch;
            end
            StTrap0: begin
                ld_reg_o  = 1'b1;
                reg_sel_o = RegSelPc;
                dr_r7_o   = 1'b1;
                ld_mar_o  = 1'b1;
                mar_sel_o = MarSelVect;
                state_d   = StTwait;
            end
            StTrap1: begin
                ld_pc_o  = 1'b1;
                pc_sel_o = PcSelMdr;
                state_d  = StFetch;
            end
            StHalt: state_d = StHalt;
            default: state_d = StHalt;
        endcase

        // Watchdog abort; expiry is already masked by a same-cycle mem_ready
        if (timeout) begin
            mem_en_o  = 1'b0;
            mem_we_o  = 1'b0;
            mem_err_d = 1'b1;
            state_d   = StHalt;
        end

        illegal_o = illegal_q;
        mem_err_o = mem_err_q | timeout;

        if (rst_i) begin
            {mem_en_o, mem_we_o, ld_pc_o, ld_ir_o, ld_mar_o, ld_mdr_o, ld_reg_o, ld_cc_o,
             pc_sel_o, mar_sel_o, ea_sel_o, reg_sel_o, dr_r7_o, mdr_sel_o, alu_op_o,
             illegal_o, mem_err_o} = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StFetch;
            illegal_q <= 1'b0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            mem_err_q <= mem_err_d;
        end
    end

endmodule

// File: tb/tb_lc3_control_fsm.sv
// Directed bench for lc3_control_fsm: per-cycle expected state and control bundle,
// written out by hand for each instruction sequence.
module tb_lc3_control_fsm;
    import lc3_control_fsm_pkg::*;

    typedef struct packed {
        logic       mem_en;
        logic       mem_we;
        logic       ld_pc;
        logic       ld_ir;
        logic       ld_mar;
        logic       ld_mdr;
        logic       ld_reg;
        logic       ld_cc;
        logic [1:0] pc_sel;
        logic [1:0] mar_sel;
        logic [1:0] ea_sel;
        logic [1:0] reg_sel;
        logic       dr_r7;
        logic       mdr_sel;
        logic [1:0] alu_op;
        logic       illegal;
        logic       mem_err;
    } ctl_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ir;
    logic [2:0]  nzp;
    logic        mem_ready;
    logic        mem_en, mem_we, ld_pc, ld_ir, ld_mar, ld_mdr, ld_reg, ld_cc;
    logic [1:0]  pc_sel, mar_sel, ea_sel, reg_sel, alu_op;
    logic        dr_r7, mdr_sel, illegal, mem_err;
    logic [4:0]  state_o;
    ctl_t        ctl;

    int n_cmp  = 0;
    int n_fail = 0;

    // Expected-sequence rows
    state_e      sq[$];
    ctl_t        cq[$];
    logic        rq[$];
    logic [15:0] iq[$];
    logic [2:0]  nq[$];
    logic [15:0] cur_ir;
    logic [2:0]  cur_nzp;

    always #5 clk = ~clk;

    lc3_control_fsm #(
        .WAIT_MAX (15)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .ir_i        (ir),
        .nzp_i       (nzp),
        .mem_ready_i (mem_ready),
        .mem_en_o    (mem_en),
        .mem_we_o    (mem_we),
        .ld_pc_o     (ld_pc),
        .ld_ir_o     (ld_ir),
        .ld_mar_o    (ld_mar),
        .ld_mdr_o    (ld_mdr),
        .ld_reg_o    (ld_reg),
        .ld_cc_o     (ld_cc),
        .pc_sel_o    (pc_sel),
        .mar_sel_o   (mar_sel),
        .ea_sel_o    (ea_sel),
        .reg_sel_o   (reg_sel),
        .dr_r7_o     (dr_r7),
        .mdr_sel_o   (mdr_sel),
        .alu_op_o    (alu_op),
        .illegal_o   (illegal),
        .mem_err_o   (mem_err),
        .state_o     (state_o)
    );

    assign ctl = {mem_en, mem_we, ld_pc, ld_ir, ld_mar, ld_mdr, ld_reg, ld_cc,
                  pc_sel, mar_sel, ea_sel, reg_sel, dr_r7, mdr_sel, alu_op, illegal, mem_err};

    function automatic ctl_t k_fetch();
        ctl_t c = '0;
        c.ld_mar = 1'b1;
        c.ld_pc  = 1'b1;
        return c;
    endfunction

    function automatic ctl_t k_rd(input logic r);
        ctl_t c = '0;
        c.mem_en = 1'b1;
        c.ld_mdr = r;
        return c;
    endfunction

    function automatic ctl_t k_ldir();
        ctl_t c = '0;
        c.ld_ir = 1'b1;
        return c;
    endfunction

    task automatic clr_seq();
        sq.delete(); cq.delete(); rq.delete(); iq.delete(); nq.delete();
    endtask

    task automatic add(input state_e s, input ctl_t c, input logic r);
        sq.push_back(s); cq.push_back(c); rq.push_back(r);
        iq.push_back(cur_ir); nq.push_back(cur_nzp);
    endtask

    // FETCH, FWAIT (ready at once), LDIR, DECODE
    task automatic add_front(input logic [15:0] i, input ctl_t dec);
        cur_ir = i;
        add(StFetch, k_fetch(), 1'b1);
        add(StFwait, k_rd(1'b1), 1'b1);
        add(StLdir, k_ldir(), 1'b1);
        add(StDecode, dec, 1'b1);
    endtask

    task automatic add_wait(input state_e s, input int n_low);
        for (int k = 0; k < n_low; k++) add(s, k_rd(1'b0), 1'b0);
        add(s, k_rd(1'b1), 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1; mem_ready = 1'b0; ir = 16'h0000; nzp = 3'b000;
        cur_ir = 16'h0000; cur_nzp = 3'b000;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; ir = 16'h1283; nzp = 3'b111; mem_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #3;
            n_cmp++;
            if (state_o !== StFetch) begin
                n_fail++;
                $display("FAIL reset_state cyc %0d got %0d want %0d", k, state_o, StFetch);
            end
            n_cmp++;
            if (ctl !== ctl_t'('0)) begin
                n_fail++;
                $display("FAIL reset_outputs cyc %0d got %h want 0", k, ctl);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0; #3;
        n_cmp++;
        if (ctl !== k_fetch()) begin
            n_fail++;
            $display("FAIL reset_release_fetch got %h want %h", ctl, k_fetch());
        end
        @(posedge clk); #1;
        n_cmp++;
        if (state_o !== StFwait) begin
            n_fail++;
            $display("FAIL reset_release_next got %0d want %0d", state_o, StFwait);
        end
    endtask

    // ADD/AND/NOT/LEA/JSR/JSRR back to back
    task automatic test_alu();
        ctl_t c;
        int   n_ldir = 0;
        do_reset();
        clr_seq();
        c = '0; c.ld_reg = 1; c.ld_cc = 1; c.alu_op = 2'd0;
        add_front(16'h1283, '0); add(StExec, c, 1'b1);
        c.alu_op = 2'd1;
        add_front(16'h5283, '0); add(StExec, c, 1'b1);
        c.alu_op = 2'd2;
        add_front(16'h927F, '0); add(StExec, c, 1'b1);
        c = '0; c.ld_reg = 1; c.reg_sel = 2'd3; c.ea_sel = 2'd0;
        add_front(16'hE205, '0); add(StExec, c, 1'b1);
        c = '0; c.ld_reg = 1; c.reg_sel = 2'd2; c.dr_r7 = 1; c.ld_pc = 1;
        c.pc_sel = 2'd1; c.ea_sel = 2'd2;
        add_front(16'h4805, '0); add(StExec, c, 1'b1);
        c.pc_sel = 2'd2; c.ea_sel = 2'd0;
        add_front(16'h4080, '0); add(StExec, c, 1'b1);
        add(StFetch, k_fetch(), 1'b1);
        for (int i = 0; i < sq.size(); i++) begin
            ir = iq[i]; nzp = nq[i]; mem_ready = rq[i]; #3;
            if (ld_ir === 1'b1) n_ldir++;
            n_cmp++;
            if (state_o !== sq[i]) begin
                n_fail++;
                $display("FAIL alu_state cyc %0d got %0d want %0d", i, state_o, sq[i]);
            end
            n_cmp++;
            if (ctl !== cq[i]) begin
                n_fail++;
                $display("FAIL alu_ctl cyc %0d got %h want %h", i, ctl, cq[i]);
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (n_ldir != 6) begin
            n_fail++;
            $display("FAIL alu_ld_ir_pulses got %0d want 6", n_ldir);
        end
    endtask

    // BRz taken, BRz not taken, JMP
    task automatic test_branch();
        ctl_t c;
        do_reset();
        clr_seq();
        c = '0; c.ld_pc = 1; c.pc_sel = 2'd1; c.ea_sel = 2'd0;
        cur_nzp = 3'b010; add_front(16'h0405, c);
        cur_nzp = 3'b100; add_front(16'h0405, '0);
        c = '0; c.ld_pc = 1; c.pc_sel = 2'd2;
        add_front(16'hC080, c);
        add(StFetch, k_fetch(), 1'b1);
        for (int i = 0; i < sq.size(); i++) begin
            ir = iq[i]; nzp = nq[i]; mem_ready = rq[i]; #3;
            n_cmp++;
            if (state_o !== sq[i]) begin
                n_fail++;
                $display("FAIL br_state cyc %0d got %0d want %0d", i, state_o, sq[i]);
            end
            n_cmp++;
            if (ctl !== cq[i]) begin
                n_fail++;
                $display("FAIL br_ctl cyc %0d got %h want %h", i, ctl, cq[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    // LDI with 3-cycle delays, then LD, LDR, STR, STI back to back
    task automatic test_memory();
        ctl_t cm0, cm1, cil, cwb, csd, cww;
        do_reset();
        clr_seq();
        cm0 = '0; cm0.ld_mar = 1; cm0.mar_sel = 2'd1; cm0.ea_sel = 2'd0;
        cm1 = cm0; cm1.ea_sel = 2'd1;
        cil = '0; cil.ld_mar = 1; cil.mar_sel = 2'd2;
        cwb = '0; cwb.ld_reg = 1; cwb.ld_cc = 1; cwb.reg_sel = 2'd1;
        csd = '0; csd.ld_mdr = 1; csd.mdr_sel = 1;
        cww = '0; cww.mem_en = 1; cww.mem_we = 1;
        cur_ir = 16'hA002;
        add(StFetch, k_fetch(), 1'b0);
        add_wait(StFwait, 3);
        add(StLdir, k_ldir(), 1'b0);
        add(StDecode, '0, 1'b0);
        add(StMaddr, cm0, 1'b0);
        add_wait(StIwait, 3);
        add(StIload, cil, 1'b0);
        add_wait(StRwait, 3);
        add(StLdwb, cwb, 1'b0);
        add_front(16'h2205, '0); add(StMaddr, cm0, 1'b1); add_wait(StRwait, 0);
        add(StLdwb, cwb, 1'b1);
        add_front(16'h6283, '0); add(StMaddr, cm1, 1'b1); add_wait(StRwait, 0);
        add(StLdwb, cwb, 1'b1);
        add_front(16'h7283, '0); add(StMaddr, cm1, 1'b1); add(StStdata, csd, 1'b1);
        add(StWwait, cww, 1'b1);
        add_front(16'hB002, '0); add(StMaddr, cm0, 1'b1); add_wait(StIwait, 0);
        add(StIload, cil, 1'b1); add(StStdata, csd, 1'b1); add(StWwait, cww, 1'b1);
        add(StFetch, k_fetch(), 1'b1);
        for (int i = 0; i < sq.size(); i++) begin
            ir = iq[i]; nzp = nq[i]; mem_ready = rq[i]; #3;
            n_cmp++;
            if (state_o !== sq[i]) begin
                n_fail++;
                $display("FAIL mem_state cyc %0d got %0d want %0d", i, state_o, sq[i]);
            end
            n_cmp++;
            if (ctl !== cq[i]) begin
                n_fail++;
                $display("FAIL mem_ctl cyc %0d got %h want %h", i, ctl, cq[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_trap();
        ctl_t c0, c1;
        do_reset();
        clr_seq();
        c0 = '0; c0.ld_reg = 1; c0.reg_sel = 2'd2; c0.dr_r7 = 1; c0.ld_mar = 1; c0.mar_sel = 2'd3;
        c1 = '0; c1.ld_pc = 1; c1.pc_sel = 2'd3;
        add_front(16'hF025, '0);
        add(StTrap0, c0, 1'b1);
        add_wait(StTwait, 0);
        add(StTrap1, c1, 1'b1);
        add(StFetch, k_fetch(), 1'b1);
        for (int i = 0; i < sq.size(); i++) begin
            ir = iq[i]; nzp = nq[i]; mem_ready = rq[i]; #3;
            n_cmp++;
            if (state_o !== sq[i]) begin
                n_fail++;
                $display("FAIL trap_state cyc %0d got %0d want %0d", i, state_o, sq[i]);
            end
            n_cmp++;
            if (ctl !== cq[i]) begin
                n_fail++;
                $display("FAIL trap_ctl cyc %0d got %h want %h", i, ctl, cq[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    // Ready never arrives (error on 15th wait cycle); then ready exactly on the 15th cycle
    task automatic test_timeout();
        ctl_t ce, ch, cx;
        for (int run = 0; run < 2; run++) begin
            do_reset();
            clr_seq();
            cur_ir = 16'h1283;
            add(StFetch, k_fetch(), 1'b0);
            for (int k = 0; k < 14; k++) add(StFwait, k_rd(1'b0), 1'b0);
            if (run == 0) begin
                ce = '0; ce.mem_err = 1;
                add(StFwait, ce, 1'b0);
                ch = '0; ch.mem_err = 1;
                add(StHalt, ch, 1'b0);
                add(StHalt, ch, 1'b1);
                add(StHalt, ch, 1'b1);
            end else begin
                add(StFwait, k_rd(1'b1), 1'b1);
                add(StLdir, k_ldir(), 1'b1);
                add(StDecode, '0, 1'b1);
                cx = '0; cx.ld_reg = 1; cx.ld_cc = 1;
                add(StExec, cx, 1'b1);
            end
            for (int i = 0; i < sq.size(); i++) begin
                ir = iq[i]; nzp = nq[i]; mem_ready = rq[i]; #3;
                n_cmp++;
                if (state_o !== sq[i]) begin
                    n_fail++;
                    $display("FAIL tmo%0d_state cyc %0d got %0d want %0d", run, i, state_o, sq[i]);
                end
                n_cmp++;
                if (ctl !== cq[i]) begin
                    n_fail++;
                    $display("FAIL tmo%0d_ctl cyc %0d got %h want %h", run, i, ctl, cq[i]);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    // RTI and RES both halt with illegal set
    task automatic test_illegal();
        ctl_t ch;
        logic [15:0] ops [2];
        ops[0] = 16'h8000;
        ops[1] = 16'hD000;
        ch = '0; ch.illegal = 1;
        for (int j = 0; j < 2; j++) begin
            do_reset();
            clr_seq();
            add_front(ops[j], '0);
            add(StHalt, ch, 1'b1);
            add(StHalt, ch, 1'b0);
            add(StHalt, ch, 1'b1);
            for (int i = 0; i < sq.size(); i++) begin
                ir = iq[i]; nzp = nq[i]; mem_ready = rq[i]; #3;
                n_cmp++;
                if (state_o !== sq[i]) begin
                    n_fail++;
                    $display("FAIL ill%0d_state cyc %0d got %0d want %0d", j, i, state_o, sq[i]);
                end
                n_cmp++;
                if (ctl !== cq[i]) begin
                    n_fail++;
                    $display("FAIL ill%0d_ctl cyc %0d got %h want %h", j, i, ctl, cq[i]);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    // Reset mid-write aborts at once and restarts at FETCH
    task automatic test_reset_mid();
        ctl_t cm, csd, cww;
        do_reset();
        clr_seq();
        cm = '0; cm.ld_mar = 1; cm.mar_sel = 2'd1;
        csd = '0; csd.ld_mdr = 1; csd.mdr_sel = 1;
        cww = '0; cww.mem_en = 1; cww.mem_we = 1;
        add_front(16'h3205, '0);
        add(StMaddr, cm, 1'b1);
        add(StStdata, csd, 1'b0);
        add(StWwait, cww, 1'b0);
        for (int i = 0; i < sq.size(); i++) begin
            ir = iq[i]; nzp = nq[i]; mem_ready = rq[i]; #3;
            n_cmp++;
            if (state_o !== sq[i]) begin
                n_fail++;
                $display("FAIL rmid_state cyc %0d got %0d want %0d", i, state_o, sq[i]);
            end
            n_cmp++;
            if (ctl !== cq[i]) begin
                n_fail++;
                $display("FAIL rmid_ctl cyc %0d got %h want %h", i, ctl, cq[i]);
            end
            @(posedge clk); #1;
        end
        mem_ready = 1'b0; #1;
        rst = 1'b1; #1;
        n_cmp++;
        if (mem_en !== 1'b0 || ctl !== ctl_t'('0)) begin
            n_fail++;
            $display("FAIL rmid_abort got mem_en=%b ctl=%h want mem_en=0 ctl=0", mem_en, ctl);
        end
        n_cmp++;
        if (state_o !== StFetch) begin
            n_fail++;
            $display("FAIL rmid_abort_state got %0d want %0d", state_o, StFetch);
        end
        @(posedge clk); #1;
        rst = 1'b0; mem_ready = 1'b1; #3;
        n_cmp++;
        if (state_o !== StFetch || ctl !== k_fetch()) begin
            n_fail++;
            $display("FAIL rmid_release got state=%0d ctl=%h want state=0 ctl=%h",
                     state_o, ctl, k_fetch());
        end
    endtask

    initial begin
        rst = 1'b1; ir = 16'h0000; nzp = 3'b000; mem_ready = 1'b0;
        cur_ir = 16'h0000; cur_nzp = 3'b000;
        test_reset();
        test_alu();
        test_branch();
        test_memory();
        test_trap();
        test_timeout();
        test_illegal();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
